// File: rtl/dmem_block_store.sv
// Backing block store for the data cache: serves 128-bit blocks with a fixed
// request-to-completion latency, sequencing a dirty writeback ahead of its fill.
module dmem_block_store #(
  parameter int LATENCY = 5,
  parameter int LINES   = 256,
  parameter int IDX_W   = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         read,
  input  logic         write,
  input  logic [31:0]  read_address,
  input  logic [31:0]  write_address,
  input  logic [127:0] write_data,
  output logic [127:0] read_data,
  output logic         read_valid,
  output logic         write_done
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, GAP} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_wb_done;
  logic [IDX_W-1:0]   r_idx;
  logic [127:0]       r_wdata;
  logic [127:0]       r_read_data;
  logic               r_read_valid;
  logic               r_write_done;
  logic [127:0]       r_mem [LINES];

  logic w_acc_wr;
  logic w_acc_rd;
  logic w_last;
  logic w_mem_we;
  logic w_unused;

  // A committed writeback is not re-accepted while the cache still holds write high.
  assign w_acc_wr = (r_state == IDLE) && write && !r_wb_done;
  assign w_acc_rd = (r_state == IDLE) && !w_acc_wr && read;
  assign w_last   = (r_cnt == '0);
  assign w_mem_we = (r_state == WRITE) && w_last;
  assign w_unused = ^{read_address[31:IDX_W+4], read_address[3:0],
                      write_address[31:IDX_W+4], write_address[3:0]};

  assign read_data  = r_read_data;
  assign read_valid = r_read_valid;
  assign write_done = r_write_done;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_wb_done    <= 1'b0;
      r_read_data  <= '0;
      r_read_valid <= 1'b0;
      r_write_done <= 1'b0;
    end else begin
      r_read_valid <= 1'b0;
      r_write_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_acc_wr) begin
            r_cnt        <= CNT_INIT;
            r_state      <= WRITE;
            r_write_done <= (LATENCY == 1);
          end else if (w_acc_rd) begin
            r_cnt   <= CNT_INIT;
            r_state <= READ;
          end else if (!write && !read) begin
            r_wb_done <= 1'b0;
          end
        end
        WRITE: begin
          if (w_last) begin
            r_wb_done <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
            // Registered pulse lands in the same cycle as the array commit.
            r_write_done <= (r_cnt == CNT_W'(1));
          end
        end
        READ: begin
          if (w_last) begin
            r_read_data  <= r_mem[r_idx];
            r_read_valid <= 1'b1;
            r_wb_done    <= 1'b0;
            r_state      <= GAP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        GAP:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_acc_wr) begin
      r_idx   <= write_address[IDX_W+3:4];
      r_wdata <= write_data;
    end else if (w_acc_rd) begin
      r_idx <= read_address[IDX_W+3:4];
    end
  end

  always_ff @(posedge clock) begin
    if (w_mem_we) r_mem[r_idx] <= r_wdata;
  end

endmodule

// File: tb/tb_dmem_block_store.sv
// Scoreboard bench for dmem_block_store: directed requests push expected pulses,
// an independent monitor pops and compares whenever a pulse appears.
module tb_dmem_block_store;
  localparam int L = 5;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         read = 1'b0;
  logic         write = 1'b0;
  logic [31:0]  read_address = '0;
  logic [31:0]  write_address = '0;
  logic [127:0] write_data = '0;
  logic [127:0] read_data;
  logic         read_valid;
  logic         write_done;

  dmem_block_store #(.LATENCY(L), .LINES(256), .IDX_W(8)) dut (
    .clock(clock), .reset(reset), .read(read), .write(write),
    .read_address(read_address), .write_address(write_address),
    .write_data(write_data), .read_data(read_data),
    .read_valid(read_valid), .write_done(write_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [127:0] data;
    int           cyc;
  } exp_t;

  exp_t rd_q[$];
  int   wr_q[$];
  exp_t mon_e;
  int   mon_c;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  localparam logic [127:0] A5  = {16{8'hA5}};
  localparam logic [127:0] D2  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] R16 = 128'hDEAD_BEEF_0000_0016_CAFE_F00D_1234_5678;
  localparam logic [127:0] D3  = 128'h0C0C_0C0C_ABCD_EF01_2345_6789_0C0C_0C0C;
  localparam logic [127:0] DX  = 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  // Monitor: every pulse must match the oldest expectation of its kind.
  always @(negedge clock) begin
    if (read_valid && write_done) flag("pulse_overlap");
    if (read_valid) begin
      if (rd_q.size() == 0) flag("unexpected_read_valid");
      else begin
        mon_e = rd_q.pop_front();
        check("read_data", read_data, mon_e.data);
        check("read_valid_cycle", 128'(cyc), 128'(mon_e.cyc));
      end
    end
    if (write_done) begin
      if (wr_q.size() == 0) flag("unexpected_write_done");
      else begin
        mon_c = wr_q.pop_front();
        check("write_done_cycle", 128'(cyc), 128'(mon_c));
      end
    end
  end

  task automatic at_cycle(input int c);
    while (cyc < c) @(negedge clock);
    #2;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((rd_q.size() != 0 || wr_q.size() != 0) && n < 40) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (rd_q.size() != 0 || wr_q.size() != 0) begin
      flag("drain_timeout");
      rd_q.delete();
      wr_q.delete();
    end
    repeat (2) @(negedge clock);
    #2;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [127:0] data);
    int a;
    write = 1'b1; write_address = addr; write_data = data;
    a = cyc + 1;
    wr_q.push_back(a + L - 1);
    at_cycle(a);
    write = 1'b0;
    wait_drain();
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [127:0] data);
    int a;
    read = 1'b1; read_address = addr;
    a = cyc + 1;
    rd_q.push_back('{data, a + L});
    at_cycle(a);
    read = 1'b0;
    wait_drain();
  endtask

  initial begin
    int a;
    repeat (3) @(negedge clock);
    check("reset_read_data", read_data, '0);
    check("reset_read_valid", 128'(read_valid), 128'(0));
    check("reset_write_done", 128'(write_done), 128'(0));
    #2 reset = 1'b1;
    repeat (2) @(negedge clock);
    #2;

    // Preload blocks 4 and 16
    do_write(32'h40, A5);
    do_write(32'h100, R16);

    // Held read: first pulse at L+1, GAP then re-acceptance, second pulse 7 later
    read = 1'b1; read_address = 32'h40;
    a = cyc + 1;
    rd_q.push_back('{A5, a + L});
    rd_q.push_back('{A5, a + 2 * L + 2});
    at_cycle(a + 2 * L + 2);
    read = 1'b0;
    wait_drain();
    check("read_data_held", read_data, A5);

    // Write then read back the same block
    do_write(32'h80, D2);
    do_read(32'h80, D2);

    // Dirty miss: both requests held until the fill lands
    write = 1'b1; write_address = 32'hC0; write_data = D3;
    read = 1'b1; read_address = 32'h100;
    a = cyc + 1;
    wr_q.push_back(a + L - 1);
    rd_q.push_back('{R16, a + 2 * L + 1});
    at_cycle(a + 2 * L + 1);
    write = 1'b0; read = 1'b0;
    wait_drain();
    do_read(32'hC0, D3);

    // Reset during the third cycle of a write
    write = 1'b1; write_address = 32'h40; write_data = DX;
    a = cyc + 1;
    at_cycle(a + 2);
    reset = 1'b0; write = 1'b0;
    #1;
    check("midreset_read_data", read_data, '0);
    check("midreset_read_valid", 128'(read_valid), 128'(0));
    check("midreset_write_done", 128'(write_done), 128'(0));
    at_cycle(a + 3);
    reset = 1'b1;
    wait_drain();
    do_read(32'h40, A5);

    // Address change after acceptance is ignored
    read = 1'b1; read_address = 32'h40;
    a = cyc + 1;
    rd_q.push_back('{A5, a + L});
    at_cycle(a);
    read = 1'b0;
    at_cycle(a + 2);
    read_address = 32'h50;
    wait_drain();

    // Upper address bits alias modulo LINES
    do_read(32'h0001_0040, A5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_block_store.md
Name: dmem_block_store

Overview:
Backing data memory behind the data-cache controller. It serves whole 128-bit cache blocks with a fixed multi-cycle latency. Dirty-victim writebacks and line fills use level-held requests and single-cycle completion pulses. When a dirty miss raises both requests at once, it sequences the writeback before the fill.

Parameters:
LATENCY, 5, cycles from request acceptance to completion pulse (>=1)
LINES, 256, number of 128-bit blocks stored
IDX_W, 8, log2(LINES); block index = address[IDX_W+3:4]

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
read  input  1  level request: fetch block at read_address
write  input  1  level request: store write_data at write_address
read_address  input  32  byte address of block to fetch; bits [3:0] ignored
write_address  input  32  byte address of block to store; bits [3:0] ignored
write_data  input  128  block to store
read_data  output  128  fetched block, valid when read_valid=1, held afterwards
read_valid  output  1  one-cycle pulse: read_data holds the requested block
write_done  output  1  one-cycle pulse: writeback committed to array

Behaviour:
- reset=0 (async): state=IDLE, counter=0, wb_done=0, read_data=0, read_valid=0, write_done=0. The storage array is not cleared.
- States: IDLE, WRITE, READ, GAP.
- IDLE transitions:
  - write=1 and wb_done=0: latch write_address index and write_data, counter=LATENCY-1, go WRITE. Write has priority over read.
  - Otherwise read=1: latch read_address index, counter=LATENCY-1, go READ.
  - Otherwise stay in IDLE.
- WRITE: decrement counter each cycle. On the cycle counter==0:
  - array[idx] <= latched data; write_done=1 for that cycle.
  - Set wb_done=1; go IDLE.
  - Acceptance-to-pulse distance = LATENCY cycles.
- READ: decrement counter each cycle. On the cycle counter==0:
  - read_data <= array[idx], visible with read_valid=1 in the following cycle.
  - Clear wb_done; go GAP.
  - Total: read_valid pulses LATENCY+1 cycles after acceptance.
- GAP: one cycle. Requests are ignored so the cache can absorb the block and drop its request; then go IDLE.
- wb_done: blocks re-acceptance of a still-asserted write after its commit (the cache keeps dirty set until the fill lands).
  - Cleared on read completion.
  - Also cleared in IDLE if write=0 and read=0.
- Latched address/data are sampled only at acceptance. Input changes during WRITE/READ have no effect.
- Request dropped mid-operation: the operation still completes and pulses. The pulse is harmless to the controller.
- read_valid and write_done are never high in the same cycle. Each is exactly one cycle wide.
- Read-after-write to the same index returns the newly written block.
- Address bits above IDX_W+3 are ignored (aliasing wraps modulo LINES).
- LATENCY=1: WRITE and READ last one cycle each. The rules above are unchanged.
- Reset asserted mid-WRITE: array unmodified, no pulse. Mid-READ: no pulse, read_data=0.

Test Plan:
1. Reset, read=1, read_address=0x40 (array[4] preloaded 0xA5..A5) → read_valid pulses exactly cycle 6 after acceptance with read_data=0xA5..A5; held after pulse; next IDLE acceptance not before cycle 8.
2. write=1, write_address=0x80, write_data=0x1111_2222_3333_4444_5555_6666_7777_8888, then read 0x80 → write_done at cycle 5; read returns same 128-bit value.
3. Dirty miss: write=1 (addr 0xC0, data D) and read=1 (addr 0x100) held together until read_valid → write_done once, then read_valid once with array[16]; array[12]=D; no second write_done although write stays high.
4. Assert reset=0 for 1 cycle at cycle 3 of a WRITE to 0x40 → no write_done, array[4] unchanged, outputs 0; next request serviced normally.
5. Change read_address from 0x40 to 0x50 two cycles after acceptance → returned block is array[4].
6. read_address=0x1_0040 with LINES=256 → returns array[4] (wrap-around).
